// File: rtl/mem_port.sv
// mem_port: RV32 load/store engine over an 8/16/32-bit synchronous byte-enabled memory.
// Splits one request into aligned bus beats, assembles and extends loads, and rejects illegal requests.
module mem_port #(
  parameter int unsigned MABL = 19,
  parameter int unsigned BUSW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [2:0]        funct3,
  input  logic [MABL-1:0]   addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              err,
  output logic [31:0]       rdata,
  input  logic [BUSW-1:0]   rd,
  output logic [BUSW/8-1:0] we,
  output logic [BUSW-1:0]   wd,
  output logic [MABL-1:0]   ad
);

  localparam int unsigned L    = BUSW / 8;
  localparam int unsigned OFFW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, XFER, TAIL, DONE} state_t;

  state_t            state;
  logic              wr_q;
  logic [2:0]        funct3_q;
  logic [MABL-1:0]   addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        cnt;
  logic [31:0]       asm_q;

  int                size_c;
  int                nbeats_c;
  int                off_c;
  int                jw;
  int                jr;
  logic              illegal_c;
  logic              last_c;
  logic [1:0]        nbeat_c;
  logic [1:0]        cbeat_c;
  logic [MABL-1:0]   beat_ad_c;
  logic [L-1:0]      beat_we_c;
  logic [BUSW-1:0]   beat_wd_c;
  logic [31:0]       merged_c;
  logic [31:0]       ext_c;

  // Request decode: size, beat count, lane offset and legality.
  always_comb begin
    size_c = 4;
    case (funct3_q[1:0])
      2'b00:   size_c = 1;
      2'b01:   size_c = 2;
      default: size_c = 4;
    endcase
    nbeats_c  = (size_c > int'(L)) ? size_c / int'(L) : 1;
    off_c     = (L > 1) ? int'(addr_q[OFFW-1:0]) : 0;
    illegal_c = (funct3_q[1:0] == 2'b01 && addr_q[0])
             || (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00)
             || (!wr_q && (funct3_q == 3'b011 || funct3_q[2:1] == 2'b11))
             || (wr_q && funct3_q[1:0] == 2'b11);
    last_c    = (cnt == 2'(nbeats_c - 1));
  end

  // Beat steering: lanes for the next beat to present, and merge of the beat being captured.
  always_comb begin
    nbeat_c   = (state == CHECK) ? 2'd0 : cnt + 2'd1;
    cbeat_c   = (state == TAIL) ? cnt : cnt - 2'd1;
    beat_ad_c = (addr_q & ~MABL'(L - 1)) + MABL'(int'(nbeat_c) * int'(L));
    beat_we_c = '0;
    beat_wd_c = '0;
    merged_c  = asm_q;
    jw        = 0;
    jr        = 0;
    for (int l = 0; l < int'(L); l++) begin
      jw = int'(nbeat_c) * int'(L) + l - off_c;
      jr = int'(cbeat_c) * int'(L) + l - off_c;
      if (jw >= 0 && jw < size_c) begin
        beat_we_c[l]          = 1'b1;
        beat_wd_c[8*l +: 8]   = wdata_q[8*jw +: 8];
      end
      if (jr >= 0 && jr < size_c) begin
        merged_c[8*jr +: 8]   = rd[8*l +: 8];
      end
    end
  end

  // Sign/zero extension of the fully assembled load.
  always_comb begin
    ext_c = merged_c;
    if (funct3_q[1:0] == 2'b00) begin
      ext_c = {{24{merged_c[7] & ~funct3_q[2]}}, merged_c[7:0]};
    end else if (funct3_q[1:0] == 2'b01) begin
      ext_c = {{16{merged_c[15] & ~funct3_q[2]}}, merged_c[15:0]};
    end
  end

  // Controller FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      we       <= '0;
      wd       <= '0;
      ad       <= '0;
      cnt      <= '0;
      wr_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            wr_q     <= wr;
            funct3_q <= funct3;
            addr_q   <= addr;
            wdata_q  <= wdata;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (illegal_c) begin
            ready <= 1'b1;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            cnt   <= '0;
            asm_q <= '0;
            ad    <= beat_ad_c;
            we    <= wr_q ? beat_we_c : '0;
            wd    <= wr_q ? beat_wd_c : '0;
            state <= XFER;
          end
        end
        XFER: begin
          // Read data trails its address by one cycle, so beat cnt-1 lands now.
          if (!wr_q && cnt != 2'd0) begin
            asm_q <= merged_c;
          end
          if (last_c) begin
            we <= '0;
            wd <= '0;
            if (wr_q) begin
              ready <= 1'b1;
              state <= DONE;
            end else begin
              state <= TAIL;
            end
          end else begin
            cnt <= cnt + 2'd1;
            ad  <= beat_ad_c;
            we  <= wr_q ? beat_we_c : '0;
            wd  <= wr_q ? beat_wd_c : '0;
          end
        end
        TAIL: begin
          asm_q <= merged_c;
          rdata <= ext_c;
          ready <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          we    <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
